// File: rtl/lamp_driver.sv
// Soft-start lamp dimmer: ramps a PWM duty between 0 and MAX_DUTY while saida is high/low.
// Duty moves one count per step period; lamp_pwm is registered (1 cycle) and never backpressures.
module lamp_driver #(
  parameter int PWM_BITS    = 8,
  parameter int MAX_DUTY    = 255,
  parameter int STEP_T      = 4,
  parameter int FAST_STEP_T = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                saida,
  input  logic                led,
  output logic                lamp_pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy,
  output logic                lamp_full
);

  localparam int MAX_T = (STEP_T > FAST_STEP_T) ? STEP_T : FAST_STEP_T;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [PWM_BITS-1:0] MAX_D   = MAX_DUTY[PWM_BITS-1:0];
  localparam logic [PWM_BITS-1:0] PWM_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [TW:0]         T_ONE   = {{TW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_shadow_q, duty_shadow_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                lamp_pwm_q, lamp_pwm_d;

  logic [TW-1:0] step_period;
  logic [TW:0]   timer_next;
  logic          step_done;

  // Comparing against the live period lets a mid-step led change end the step early.
  assign step_period = led ? FAST_STEP_T[TW-1:0] : STEP_T[TW-1:0];
  assign timer_next  = {1'b0, timer_q} + T_ONE;
  assign step_done   = (timer_next >= {1'b0, step_period});

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    timer_d = '0;
    case (state_q)
      OFF: begin
        if (saida) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!saida) begin
          state_d = RAMP_DOWN;
        end else if (step_done) begin
          if (duty_q >= MAX_D - 1'b1) begin
            duty_d  = MAX_D;
            state_d = ON;
          end else begin
            duty_d = duty_q + 1'b1;
          end
        end else begin
          timer_d = timer_next[TW-1:0];
        end
      end
      ON: begin
        if (!saida) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (saida) begin
          state_d = RAMP_UP;
        end else if (step_done) begin
          if (duty_q <= {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
            duty_d  = '0;
            state_d = OFF;
          end else begin
            duty_d = duty_q - 1'b1;
          end
        end else begin
          timer_d = timer_next[TW-1:0];
        end
      end
      default: state_d = OFF;
    endcase
  end

  // The shadow is latched at count 0 and used for the whole period, so periods are never cut.
  always_comb begin
    pwm_cnt_d     = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + 1'b1;
    duty_shadow_d = (pwm_cnt_q == '0) ? duty_q : duty_shadow_q;
    lamp_pwm_d    = (pwm_cnt_q < duty_shadow_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= OFF;
      duty_q        <= '0;
      duty_shadow_q <= '0;
      pwm_cnt_q     <= '0;
      timer_q       <= '0;
      lamp_pwm_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      duty_shadow_q <= duty_shadow_d;
      pwm_cnt_q     <= pwm_cnt_d;
      timer_q       <= timer_d;
      lamp_pwm_q    <= lamp_pwm_d;
    end
  end

  assign lamp_pwm  = lamp_pwm_q;
  assign duty      = duty_q;
  assign busy      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign lamp_full = (state_q == ON);

endmodule

// File: doc/lamp_driver.md
LAMP_DRIVER -- requirements
Module: lamp_driver

Interface
REQ-001 The module SHALL have parameter PWM_BITS, default 8, giving the duty and PWM counter width.
REQ-002 The module SHALL have parameter MAX_DUTY, default 255, giving the full-brightness duty; its legal range is 1..2^PWM_BITS-1.
REQ-003 The module SHALL have parameter STEP_T, default 4, giving the clk cycles per duty step in normal mode; minimum 1.
REQ-004 The module SHALL have parameter FAST_STEP_T, default 1, giving the clk cycles per duty step in manual mode; minimum 1.
REQ-005 The module SHALL have port clk, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-007 The module SHALL have port saida, input, 1 bit, the lamp-on request from the lighting controller, synchronous to clk.
REQ-008 The module SHALL have port led, input, 1 bit, the controller's manual-mode indicator; 1 selects FAST_STEP_T.
REQ-009 The module SHALL have port lamp_pwm, output, 1 bit, the PWM drive to the lamp power stage.
REQ-010 The module SHALL have port duty, output, PWM_BITS bits, the current target brightness.
REQ-011 The module SHALL have port busy, output, 1 bit, asserted while in RAMP_UP or RAMP_DOWN.
REQ-012 The module SHALL have port lamp_full, output, 1 bit, asserted while in ON.

Function
REQ-013 The FSM SHALL have exactly four states: OFF, RAMP_UP, ON and RAMP_DOWN.
REQ-014 From OFF, saida=1 SHALL cause entry to RAMP_UP on the next edge; otherwise the FSM SHALL remain in OFF.
REQ-015 RAMP_UP SHALL increment duty by 1 every step period: STEP_T cycles when led=0, FAST_STEP_T cycles when led=1.
REQ-016 When duty reaches MAX_DUTY in RAMP_UP, the FSM SHALL enter ON; duty SHALL never exceed MAX_DUTY.
REQ-017 Any state other than OFF SHALL go to RAMP_DOWN on saida=0, continuing from the current duty with no jump.
REQ-018 RAMP_DOWN SHALL decrement duty by 1 per step period.
REQ-019 When duty reaches 0 in RAMP_DOWN, the FSM SHALL enter OFF; duty SHALL never wrap below 0.
REQ-020 RAMP_DOWN with saida=1 SHALL return to RAMP_UP from the current duty.
REQ-021 The step timer SHALL clear to 0 on every state change.
REQ-022 The first duty change after entering a ramp state SHALL occur exactly one step period after entry.
REQ-023 The led input SHALL be sampled each cycle.
REQ-024 A change on led mid-step SHALL take effect at the next timer comparison; the timer SHALL be clamped so the current step ends no later than the new period.
REQ-025 The PWM counter SHALL free-run from 0 to 2^PWM_BITS-2 and then wrap to 0, giving a period of 2^PWM_BITS-1 cycles.
REQ-026 lamp_pwm SHALL be registered and equal to (pwm_cnt < duty_shadow).
REQ-027 duty_shadow SHALL load duty only when pwm_cnt=0, so that no PWM period is ever truncated.
REQ-028 duty=0 SHALL give lamp_pwm constantly 0.
REQ-029 duty=2^PWM_BITS-1 SHALL give lamp_pwm constantly 1.
REQ-030 Total ramp time from 0 to MAX_DUTY SHALL be exactly MAX_DUTY×step period cycles, plus 1 cycle of FSM entry.
REQ-031 If saida toggles in the same cycle that duty reaches its limit, the toggle SHALL win and the FSM SHALL enter the opposite ramp state.

Reset
REQ-032 While rst=1, the FSM SHALL be OFF.
REQ-033 While rst=1, duty, duty_shadow, pwm_cnt and the step timer SHALL all be 0.
REQ-034 While rst=1, lamp_pwm, busy and lamp_full SHALL all be 0.
REQ-035 Reset SHALL take effect immediately, including mid-ramp or mid-PWM-period.
REQ-036 After rst deasserts, the FSM SHALL leave OFF only on a sampled saida=1.

Verification (PWM_BITS=8, MAX_DUTY=255, STEP_T=4, FAST_STEP_T=1)
REQ-037 Assert rst for 3 cycles with saida=1 -> all outputs 0 during reset; busy=1 one cycle after rst falls.
REQ-038 Hold saida=1, led=0 from OFF -> duty=1 at 5 cycles; duty=255 and lamp_full=1 at 1021 cycles; lamp_pwm constantly 1 after the next PWM wrap.
REQ-039 Drop saida when duty=100 in RAMP_UP -> RAMP_DOWN next cycle with duty still 100; duty=0, OFF and busy=0 after 400 more cycles.
REQ-040 Freeze duty at 64 -> lamp_pwm high exactly 64 of every 255 cycles; a duty change mid-period does not alter the current period.
REQ-041 With led=1 and saida=1 from OFF -> lamp_full=1 after 256 cycles; toggling led mid-ramp changes the step rate within one step.
REQ-042 Pulse rst mid-RAMP_DOWN at duty=50 -> lamp_pwm=0 and duty=0 within the same cycle; FSM in OFF.
